// File: rtl/seq_det_pkg.sv
// Shared constants for the serial sequence detector: visible state encoding and the
// legal pattern-width range.
package seq_det_pkg;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_HUNT  = 2'b10,
    ST_MATCH = 2'b11
  } state_e;

  function automatic bit pat_w_ok(input int unsigned w);
    return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Control, pattern and status signals of the serial sequence detector.
interface seq_detector_param_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) ();
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic              en;
  logic              data_input;
  logic              pat_load;
  logic [PAT_W-1:0]  pat_value;
  logic              overlap;
  logic              clr_count;
  logic              data_output;
  logic [CNT_W-1:0]  match_count;
  logic [FILL_W-1:0] fill;
  logic [1:0]        state;

  modport master (
    output en, data_input, pat_load, pat_value, overlap, clr_count,
    input  data_output, match_count, fill, state
  );

  modport slave (
    input  en, data_input, pat_load, pat_value, overlap, clr_count,
    output data_output, match_count, fill, state
  );
endinterface

// File: rtl/sat_counter.sv
// Up counter that sticks at its maximum value; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial sequence detector with a run-time loadable pattern, overlap selection, sample
// enable, saturating match counter and visible state.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned       PAT_W       = 4,
  parameter int unsigned       CNT_W       = 8,
  parameter logic [PAT_W-1:0]  DEFAULT_PAT = PAT_W'(4'b1101)
) (
  input logic                 clock,
  input logic                 rst,
  seq_detector_param_if.slave bus
);

  localparam int unsigned      FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);

  if (!pat_w_ok(PAT_W)) begin : g_pat_w_check
    $error("seq_detector_param: PAT_W must be within 2..32");
  end

  logic [PAT_W-1:0] r_pat, w_pat_d;
  logic [PAT_W-1:0] r_sr, w_sr_d;
  logic [FW-1:0]    r_fill, w_fill_d;
  logic             r_out, w_out_d;
  state_e           r_state, w_state_d;
  logic             w_match;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_pat   <= DEFAULT_PAT;
      r_sr    <= '0;
      r_fill  <= '0;
      r_out   <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_pat   <= w_pat_d;
      r_sr    <= w_sr_d;
      r_fill  <= w_fill_d;
      r_out   <= w_out_d;
      r_state <= w_state_d;
    end
  end

  // A load restarts the hunt; idle cycles simply freeze the history so bits on either
  // side of an enable gap join up.
  always_comb begin
    w_pat_d   = r_pat;
    w_sr_d    = r_sr;
    w_fill_d  = r_fill;
    w_out_d   = 1'b0;
    w_state_d = ST_IDLE;
    w_match   = 1'b0;
    if (bus.pat_load) begin
      w_pat_d  = bus.pat_value;
      w_sr_d   = '0;
      w_fill_d = '0;
    end else if (bus.en) begin
      w_sr_d   = {r_sr[PAT_W-2:0], bus.data_input};
      w_fill_d = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FW'(1);
      w_match  = (w_fill_d == FILL_FULL) && (w_sr_d == r_pat);
      w_out_d  = w_match;
      if (w_match) begin
        w_state_d = ST_MATCH;
        if (!bus.overlap) begin
          w_fill_d = '0;
        end
      end else if (w_fill_d == FILL_FULL) begin
        w_state_d = ST_HUNT;
      end else begin
        w_state_d = ST_FILL;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clock   (clock),
    .rst     (rst),
    .i_inc   (w_match),
    .i_clr   (bus.clr_count),
    .o_count (bus.match_count)
  );

  assign bus.data_output = r_out;
  assign bus.fill        = r_fill;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: pattern 1101 default, counter width 2.
module tb_seq_detector_param;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FILL  = 2'b01;
  localparam logic [1:0] S_HUNT  = 2'b10;
  localparam logic [1:0] S_MATCH = 2'b11;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(
    .PAT_W       (PAT_W),
    .CNT_W       (CNT_W),
    .DEFAULT_PAT (4'b1101)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit with en=1 and land 1 ns after the sampling edge.
  task automatic bit_in(input logic d);
    bus.en         = 1'b1;
    bus.data_input = d;
    @(posedge clock);
    #1;
  endtask

  // Load a pattern (optionally clearing the count) in a single cycle.
  task automatic load(input logic [PAT_W-1:0] p, input logic clr);
    bus.pat_load  = 1'b1;
    bus.pat_value = p;
    bus.clr_count = clr;
    bus.en        = 1'b1;
    @(posedge clock);
    #1;
    bus.pat_load  = 1'b0;
    bus.clr_count = 1'b0;
  endtask

  logic [6:0] exp_pulse;

  initial begin
    bus.en = 1'b0; bus.data_input = 1'b0; bus.pat_load = 1'b0;
    bus.pat_value = '0; bus.overlap = 1'b1; bus.clr_count = 1'b0;

    #2;
    check("reset_out",   {31'd0, bus.data_output}, 32'd0);
    check("reset_count", {30'd0, bus.match_count}, 32'd0);
    check("reset_fill",  {29'd0, bus.fill},        32'd0);
    check("reset_state", {30'd0, bus.state},       {30'd0, S_IDLE});
    #10 rst = 1'b1;
    @(posedge clock); #1;
    check("idle_state",  {30'd0, bus.state},       {30'd0, S_IDLE});

    // 1: overlapping 1101101
    bus.overlap = 1'b1;
    exp_pulse = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      bit_in((i == 2 || i == 5) ? 1'b0 : 1'b1);
      check($sformatf("t1_pulse%0d", i + 1), {31'd0, bus.data_output},
            {31'd0, exp_pulse[6-i]});
      if (i == 0) check("t1_state_fill", {30'd0, bus.state}, {30'd0, S_FILL});
      if (i == 3) check("t1_state_match", {30'd0, bus.state}, {30'd0, S_MATCH});
      if (i == 4) check("t1_state_hunt", {30'd0, bus.state}, {30'd0, S_HUNT});
    end
    check("t1_count", {30'd0, bus.match_count}, 32'd2);

    load(4'b1101, 1'b1);
    check("reload_count", {30'd0, bus.match_count}, 32'd0);
    check("reload_fill",  {29'd0, bus.fill},        32'd0);
    check("reload_state", {30'd0, bus.state},       {30'd0, S_IDLE});

    // 2: non-overlapping 1101101
    bus.overlap = 1'b0;
    exp_pulse = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      bit_in((i == 2 || i == 5) ? 1'b0 : 1'b1);
      check($sformatf("t2_pulse%0d", i + 1), {31'd0, bus.data_output},
            {31'd0, exp_pulse[6-i]});
      if (i == 3) check("t2_fill4", {29'd0, bus.fill}, 32'd0);
      if (i == 4) check("t2_state_fill", {30'd0, bus.state}, {30'd0, S_FILL});
    end
    check("t2_fill7", {29'd0, bus.fill},        32'd3);
    check("t2_count", {30'd0, bus.match_count}, 32'd1);

    // 3: pattern 0000, six zeros, overlapping
    bus.overlap = 1'b1;
    load(4'b0000, 1'b1);
    check("t3_load_state", {30'd0, bus.state},       {30'd0, S_IDLE});
    check("t3_load_out",   {31'd0, bus.data_output}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      bit_in(1'b0);
      check($sformatf("t3_pulse%0d", i + 1), {31'd0, bus.data_output},
            (i >= 3) ? 32'd1 : 32'd0);
    end
    check("t3_count", {30'd0, bus.match_count}, 32'd3);
    check("t3_fill",  {29'd0, bus.fill},        32'd4);

    // 4: 11, two-cycle en gap, 01
    load(4'b1101, 1'b1);
    bit_in(1'b1);
    bit_in(1'b1);
    check("t4_pre_state", {30'd0, bus.state}, {30'd0, S_FILL});
    bus.en = 1'b0; bus.data_input = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check("t4_gap_state", {30'd0, bus.state},       {30'd0, S_IDLE});
      check("t4_gap_out",   {31'd0, bus.data_output}, 32'd0);
      check("t4_gap_fill",  {29'd0, bus.fill},        32'd2);
    end
    bit_in(1'b0);
    check("t4_bit3_out", {31'd0, bus.data_output}, 32'd0);
    bit_in(1'b1);
    check("t4_bit4_out",   {31'd0, bus.data_output}, 32'd1);
    check("t4_post_state", {30'd0, bus.state},       {30'd0, S_MATCH});
    check("t4_count",      {30'd0, bus.match_count}, 32'd1);

    // 5: saturation at 3, then clear on the 6th match
    load(4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) bit_in(1'b0);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b0);
      check($sformatf("t5_count%0d", i + 1), {30'd0, bus.match_count},
            (i >= 2) ? 32'd3 : 32'(i + 1));
    end
    bus.clr_count = 1'b1;
    bit_in(1'b0);
    bus.clr_count = 1'b0;
    check("t5_clr_pulse", {31'd0, bus.data_output}, 32'd1);
    check("t5_clr_count", {30'd0, bus.match_count}, 32'd0);
    bit_in(1'b0);
    check("t5_after_clr", {30'd0, bus.match_count}, 32'd1);

    // 6: async reset mid-stream restores the default pattern
    load(4'b0110, 1'b0);
    bit_in(1'b0);
    bit_in(1'b1);
    bit_in(1'b1);
    check("t6_pre_fill", {29'd0, bus.fill}, 32'd3);
    rst = 1'b0;
    #1;
    check("t6_rst_out",   {31'd0, bus.data_output}, 32'd0);
    check("t6_rst_count", {30'd0, bus.match_count}, 32'd0);
    check("t6_rst_fill",  {29'd0, bus.fill},        32'd0);
    check("t6_rst_state", {30'd0, bus.state},       {30'd0, S_IDLE});
    #2 rst = 1'b1;
    bit_in(1'b0);
    check("t6_out0",  {31'd0, bus.data_output}, 32'd0);
    check("t6_fill1", {29'd0, bus.fill},        32'd1);
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    check("t6_no_old_pat", {31'd0, bus.data_output}, 32'd0);
    bit_in(1'b1);
    check("t6_default_pat", {31'd0, bus.data_output}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
